// File: rtl/acc_pkg.sv
// acc_bank shared definitions: control bit positions and lane helpers.
`ifndef RAM_READ_LATENCY
`define RAM_READ_LATENCY 1
`endif

package acc_pkg;
  localparam int VLD_BIT   = 0;
  localparam int LAST_BIT  = 7;
  localparam int FIRST_BIT = 8;

  // Bit offset of lane k in a flat bus of w-bit lanes.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

  // Clamp a sign-extended value to the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] r, input int dw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction
endpackage

// File: rtl/acc_bank_if.sv
// Control/psum input and result output bundle of acc_bank.
interface acc_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CTRL_WIDTH = 9,
  parameter int NUM_CH     = 4
);
  logic [CTRL_WIDTH-1:0]        ctrl;
  logic [NUM_CH*DATA_WIDTH-1:0] psum;
  logic                         out_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] data_out;
  logic [NUM_CH-1:0]            sat_flags;
  logic                         out_valid;
  logic                         overflow_err;

  modport master (output ctrl, psum, out_ready,
                  input  data_out, sat_flags, out_valid, overflow_err);
  modport slave  (input  ctrl, psum, out_ready,
                  output data_out, sat_flags, out_valid, overflow_err);
endinterface

// File: rtl/acc_bank_ctrl_delay_line.sv
// Resettable shift register aligning the control word with its psum beat.
module ctrl_delay_line #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] dly_pipe;

  // Shift one stage per cycle; reset flushes any in-flight control.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_pipe <= '0;
    end else begin
      dly_pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) dly_pipe[i] <= dly_pipe[i-1];
    end
  end

  assign dout = dly_pipe[DEPTH-1];
endmodule

// File: rtl/acc_bank.sv
// NUM_CH-lane psum accumulator with rescale/saturate and a 2-entry result FIFO.
module acc_bank
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int CTRL_WIDTH = 9,
  parameter int NUM_CH     = 4,
  parameter int CTRL_DELAY = `RAM_READ_LATENCY + 2,
  parameter int SHIFT      = 0,
  parameter int SAT_EN     = 1
) (
  input  logic      clk,
  input  logic      rst,
  acc_bank_if.slave bus
);
  typedef struct packed {
    logic [NUM_CH-1:0]                 sat;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] data;
  } ent_t;

  logic [CTRL_WIDTH-1:0]             dctrl;
  logic                              v, f, l, f_eff, pend_first;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] res;
  logic [NUM_CH-1:0]                 rsat;
  logic                              unused_ctrl;

  ent_t       mem [2];
  logic       wptr, rptr, ovf;
  logic [1:0] cnt;
  logic       pop, full, do_push;

  ctrl_delay_line #(.WIDTH(CTRL_WIDTH), .DEPTH(CTRL_DELAY)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.ctrl),
    .dout (dctrl)
  );

  assign v           = dctrl[VLD_BIT];
  assign l           = dctrl[LAST_BIT];
  assign f           = dctrl[FIRST_BIT];
  assign unused_ctrl = ^dctrl;
  // A first marker on an idle beat still restarts the next valid beat.
  assign f_eff       = f | pend_first;

  // Hold a first marker seen without valid until the next valid beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)   pend_first <= 1'b0;
    else if (v) pend_first <= 1'b0;
    else if (f) pend_first <= 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] ps;
    logic signed [ACC_WIDTH-1:0]  acc, base, nxt, shr;
    logic signed [63:0]           r64, c64;

    assign ps   = bus.psum[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH];
    assign base = f_eff ? '0 : acc;
    assign nxt  = v ? base + ACC_WIDTH'(ps) : acc;
    assign shr  = nxt >>> SHIFT;
    assign r64  = 64'(shr);
    assign c64  = sat_clamp(r64, DATA_WIDTH);
    assign res[k]  = (SAT_EN != 0) ? c64[DATA_WIDTH-1:0] : shr[DATA_WIDTH-1:0];
    assign rsat[k] = (SAT_EN != 0) ? (c64 != r64) : 1'b0;

    // Lane accumulator; wraps modulo 2^ACC_WIDTH.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) acc <= '0;
      else      acc <= nxt;
    end
  end

  assign full    = (cnt == 2'd2);
  assign pop     = bus.out_valid & bus.out_ready;
  // When full, a simultaneous pop frees the head slot, which is the write slot.
  assign do_push = l & (!full | pop);

  // Two-entry result FIFO with sticky drop indication.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      cnt    <= 2'd0;
      ovf    <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= '{sat: rsat, data: res};
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      if (l && full && !pop) ovf <= 1'b1;
      cnt <= cnt + {1'b0, do_push} - {1'b0, pop};
    end
  end

  assign bus.out_valid    = (cnt != 2'd0);
  assign bus.data_out     = mem[rptr].data;
  assign bus.sat_flags    = mem[rptr].sat;
  assign bus.overflow_err = ovf;
endmodule

// File: tb/tb_acc_bank.sv
// Scoreboard bench for acc_bank: three configs driven by one stimulus stream.
module tb_acc_bank;
  localparam logic [8:0] V = 9'h001, L = 9'h080, F = 9'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  ctrl;
  logic [31:0] psum;
  logic        out_ready;
  logic [31:0] pq [3];
  logic [35:0] q0[$], q1[$], q2[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  acc_bank_if #(.DATA_WIDTH(8), .CTRL_WIDTH(9), .NUM_CH(4)) if0 ();
  acc_bank_if #(.DATA_WIDTH(8), .CTRL_WIDTH(9), .NUM_CH(4)) if1 ();
  acc_bank_if #(.DATA_WIDTH(8), .CTRL_WIDTH(9), .NUM_CH(4)) if2 ();

  assign if0.ctrl = ctrl;  assign if0.psum = psum;  assign if0.out_ready = out_ready;
  assign if1.ctrl = ctrl;  assign if1.psum = psum;  assign if1.out_ready = out_ready;
  assign if2.ctrl = ctrl;  assign if2.psum = psum;  assign if2.out_ready = out_ready;

  acc_bank #(.SHIFT(0), .SAT_EN(1)) d0 (.clk(clk), .rst(rst), .bus(if0.slave));
  acc_bank #(.SHIFT(0), .SAT_EN(0)) d1 (.clk(clk), .rst(rst), .bus(if1.slave));
  acc_bank #(.SHIFT(2), .SAT_EN(1)) d2 (.clk(clk), .rst(rst), .bus(if2.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic ex(input logic [35:0] e0, input logic [35:0] e1, input logic [35:0] e2);
    q0.push_back(e0); q1.push_back(e1); q2.push_back(e2);
  endtask

  // One cycle: ctrl now, its psum three cycles later (CTRL_DELAY = 3).
  task automatic step(input logic [8:0] c, input logic [31:0] p);
    ctrl  = c;
    psum  = pq[2];
    pq[2] = pq[1];
    pq[1] = pq[0];
    pq[0] = p;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(9'h000, 32'h0);
  endtask

  // Monitor: every accepted output of each instance is popped and compared.
  always @(negedge clk) begin
    if (if0.out_valid && out_ready) begin
      if (q0.size() == 0) begin checks++; errors++; $display("FAIL d0 unexpected out got=%h", if0.data_out); end
      else chk("d0 out", {28'h0, if0.sat_flags, if0.data_out}, {28'h0, q0.pop_front()});
    end
    if (if1.out_valid && out_ready) begin
      if (q1.size() == 0) begin checks++; errors++; $display("FAIL d1 unexpected out got=%h", if1.data_out); end
      else chk("d1 out", {28'h0, if1.sat_flags, if1.data_out}, {28'h0, q1.pop_front()});
    end
    if (if2.out_valid && out_ready) begin
      if (q2.size() == 0) begin checks++; errors++; $display("FAIL d2 unexpected out got=%h", if2.data_out); end
      else chk("d2 out", {28'h0, if2.sat_flags, if2.data_out}, {28'h0, q2.pop_front()});
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, " d0"}, {26'h0, if0.out_valid, if0.overflow_err, if0.sat_flags, if0.data_out}, 64'h0);
    chk({nm, " d1"}, {26'h0, if1.out_valid, if1.overflow_err, if1.sat_flags, if1.data_out}, 64'h0);
    chk({nm, " d2"}, {26'h0, if2.out_valid, if2.overflow_err, if2.sat_flags, if2.data_out}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ctrl = '0; psum = '0; out_ready = 1'b1;
    pq[0] = '0; pq[1] = '0; pq[2] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset state");
    rst = 1'b1;
    idle(2);

    // Four-beat kernel; lane0 1+2+3+4, lane1 100, lane2 -4.
    ex(36'h0_00FC640A, 36'h0_00FC640A, 36'h0_00FF1902);
    step(F | V, pk(1, 10, -1, 0));
    step(V,     pk(2, 20, -1, 0));
    step(V,     pk(3, 30, -1, 0));
    step(L | V, pk(4, 40, -1, 0));
    idle(2);
    chk("latency valid low on last beat", {63'h0, if0.out_valid}, 64'h0);
    idle(1);
    chk("latency valid high after last beat", {63'h0, if0.out_valid}, 64'h1);
    idle(3);

    // Saturation / truncation / shift: sums 400, -400, 40, -5.
    ex(36'h3_FB28807F, 36'h0_FB287090, 36'h0_FE0A9C64);
    step(F | V, pk(100, -100, 10, -2));
    step(V,     pk(100, -100, 10, -1));
    step(V,     pk(100, -100, 10, -1));
    step(L | V, pk(100, -100, 10, -1));
    idle(6);

    // First on an idle beat is held until the next valid beat.
    ex(36'h0_00000007, 36'h0_00000007, 36'h0_00000001);
    step(F,     pk(50, 119, -3, 9));
    step(V,     pk(3, 0, 0, 0));
    step(L | V, pk(4, 0, 0, 0));
    idle(6);

    // Back-to-back kernels without a bubble: 5+6, then 1+2.
    ex(36'h0_0000000B, 36'h0_0000000B, 36'h0_00000002);
    ex(36'h0_00000003, 36'h0_00000003, 36'h0_00000000);
    step(F | V, pk(5, 0, 0, 0));
    step(L | V, pk(6, 0, 0, 0));
    step(F | V, pk(1, 0, 0, 0));
    step(L | V, pk(2, 0, 0, 0));
    idle(6);

    // Full FIFO with a pop in the same cycle as a new push: nothing lost.
    ex(36'h0_00000014, 36'h0_00000014, 36'h0_00000005);
    ex(36'h0_00000015, 36'h0_00000015, 36'h0_00000005);
    ex(36'h0_00000016, 36'h0_00000016, 36'h0_00000005);
    out_ready = 1'b0;
    step(F | L | V, pk(20, 0, 0, 0));
    step(F | L | V, pk(21, 0, 0, 0));
    step(F | L | V, pk(22, 0, 0, 0));
    idle(2);
    out_ready = 1'b1;
    idle(5);
    chk("no overflow on push+pop when full", {61'h0, if2.overflow_err, if1.overflow_err, if0.overflow_err}, 64'h0);

    // Overflow: third result dropped while stalled.
    ex(36'h0_00000005, 36'h0_00000005, 36'h0_00000001);
    ex(36'h0_00000006, 36'h0_00000006, 36'h0_00000001);
    out_ready = 1'b0;
    step(F | L | V, pk(5, 0, 0, 0));
    step(F | L | V, pk(6, 0, 0, 0));
    step(F | L | V, pk(7, 0, 0, 0));
    idle(2);
    chk("overflow clear before drop", {61'h0, if2.overflow_err, if1.overflow_err, if0.overflow_err}, 64'h0);
    idle(1);
    chk("overflow set after drop", {61'h0, if2.overflow_err, if1.overflow_err, if0.overflow_err}, 64'h7);
    chk("fifo data stable while stalled", {32'h0, if0.data_out}, 64'h5);
    out_ready = 1'b1;
    idle(5);
    chk("overflow sticky", {63'h0, if0.overflow_err}, 64'h1);

    // Reset mid-kernel discards partial sums and in-flight control.
    step(F | V, pk(1, 0, 0, 0));
    step(V,     pk(2, 0, 0, 0));
    step(L | V, pk(4, 0, 0, 0));
    idle(2);
    rst = 1'b0;
    #1;
    chk_zero("mid reset");
    idle(3);
    rst = 1'b1;
    chk("valid low after reset release", {63'h0, if0.out_valid}, 64'h0);
    idle(2);
    chk("valid low after flush", {63'h0, if0.out_valid}, 64'h0);
    ex(36'h0_0000000A, 36'h0_0000000A, 36'h0_00000002);
    step(F | V, pk(9, 0, 0, 0));
    step(L | V, pk(1, 0, 0, 0));
    idle(6);

    for (int i = 0; i < 100 && (q0.size() + q1.size() + q2.size()) != 0; i++) idle(1);
    chk("d0 queue drained", 64'(q0.size()), 64'h0);
    chk("d1 queue drained", 64'(q1.size()), 64'h0);
    chk("d2 queue drained", 64'(q2.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/acc_bank.md
# acc_bank

Multi-channel successor to the single-lane multiply-accumulate accumulator at the PE output. Accumulates NUM_CH signed partial sums in parallel under one control word, rescales and saturates each finished kernel result, and hands results downstream through a valid/ready output with a 2-entry skid FIFO. Sits between the PE multiplier array and the output writer.

## Interface
- DATA_WIDTH, 8: width of each signed psum lane and each output lane.
- ACC_WIDTH, 20: internal signed accumulator width per lane, ≥ DATA_WIDTH.
- CTRL_WIDTH, 9: control word width.
- NUM_CH, 4: parallel lanes.
- CTRL_DELAY, `RAM_READ_LATENCY+2: cycles from ctrl to its aligned psum beat, ≥1.
- SHIFT, 0: arithmetic right shift applied to each result before narrowing, 0..ACC_WIDTH-DATA_WIDTH.
- SAT_EN, 1: 1 = saturate to DATA_WIDTH signed, 0 = truncate.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ctrl  in  CTRL_WIDTH  bit0 valid, bit7 last, bit8 first; other bits ignored.
- psum  in  NUM_CH*DATA_WIDTH  signed lanes, lane k at [k*DATA_WIDTH +: DATA_WIDTH].
- out_ready  in  1  downstream accepts.
- data_out  out  NUM_CH*DATA_WIDTH  FIFO head result, same packing.
- sat_flags  out  NUM_CH  per-lane saturation of head result.
- out_valid  out  1  FIFO non-empty.
- overflow_err  out  1  sticky: a result was dropped.

## Operation
- ctrl passes through a resettable CTRL_DELAY-stage line; decoded bits (v, f, l) apply to the psum present in the same cycle.
- Per lane, when v: acc <= (f ? 0 : acc) + sext(psum). Wraps modulo 2^ACC_WIDTH; sizing ACC_WIDTH is the integrator's job.
- When l: push into FIFO the lane values acc_next (post-update if v, else current acc). f&l&v yields psum alone.
- Narrowing per lane: r = acc >>> SHIFT; SAT_EN=1: clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], sat_flag=1 iff clamped; SAT_EN=0: low DATA_WIDTH bits, sat_flag=0.
- FIFO, 2 entries: pop when out_valid & out_ready. Push and pop same cycle always legal, including when full. Push when full without pop: new result dropped, overflow_err set until reset.
- f without v: no acc change (f only gates the next valid beat's start — f held in a pending bit until the next v, cleared by it).

## Timing
- Reset (asserted): acc=0, delay line=0, pending-first=0, FIFO empty, out_valid=0, data_out=0, sat_flags=0, overflow_err=0. Reset mid-kernel discards in-flight ctrl and partial sums; first ctrl after deassert is honoured normally.
- ctrl at edge t: decoded at cycle t+CTRL_DELAY; acc updated at that cycle's closing edge.
- Last beat at cycle t+D with empty FIFO: out_valid=1 and data_out valid in cycle t+D+1 (one-cycle result latency).
- data_out/sat_flags stable while out_valid & !out_ready.
- Back-to-back kernels (l on beat n, f on beat n+1) run without bubbles.

## Structure
- Shared package acc_pkg: control bit indices (VLD_BIT=0, LAST_BIT=7, FIRST_BIT=8), saturation helper function, lane slicing function.
- Sub-module ctrl_delay_line (resettable CTRL_WIDTH×CTRL_DELAY shift register); FIFO and lanes inline via generate.

## Test plan
- NUM_CH=4, D=3: ctrl f+v, v, v, l+v with lane0 psum 1,2,3,4 -> lane0 data_out=10, out_valid 1 cycle after last beat.
- Lane psum +100 ×4 with SAT_EN=1, SHIFT=0 -> data_out lane=127, sat_flag=1; psum -100 ×4 -> -128, sat_flag=1; SAT_EN=0 -> 400 mod 256 = -112 (0x90), sat_flag=0.
- SHIFT=2, sum 40 -> output 10; sum -5 -> -2 (arithmetic shift).
- out_ready=0, three single-beat kernels (f+l+v, values 5,6,7) -> FIFO holds 5,6; 7 dropped; overflow_err=1; raise out_ready -> pops 5 then 6.
- FIFO full, out_ready=1 same cycle as new last -> no drop, order preserved, overflow_err stays 0.
- Assert rst mid-kernel after two valid beats, deassert, run f+v(9), l+v(1) -> output 10, no residue, out_valid low during and right after reset.
